// File: rtl/studio2_keypad.sv
// studio2_keypad: decodes PS/2 make/break events and external key levels into
// a per-pad 16-key held bitmap. It also latches the CPU key select and drives
// the active-low per-pad EF flags for the selected key.
// Latency: PS/2 toggle to ef_n is 2 cycles, OUT strobe to key_sel is 1 cycle,
// and ext_keys to ef_n is 3 cycles.
// Backpressure: none; every input event is consumed in the cycle it is seen.
// Ports: clk_sys/reset_n (async active-low); ps2_key {toggle,pressed,ext,code};
//   ext_keys (pad p key k at bit p*16+k); io_out/io_n/io_dout (CPU OUT bus);
//   key_sel, ef_n, key_any and pad_state are registered outputs.
// Optional feature: define STUDIO2_KEY_STRETCH_EN to keep short taps visible
//   for at least MIN_HOLD cycles.
module studio2_keypad #(
  parameter int         NUM_PADS = 2,
  parameter int         MIN_HOLD = 65536,
  parameter logic [2:0] SEL_PORT = 3'd2
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic [10:0]           ps2_key,
  input  logic [16*NUM_PADS-1:0] ext_keys,
  input  logic                  io_out,
  input  logic [2:0]            io_n,
  input  logic [7:0]            io_dout,
  output logic [3:0]            key_sel,
  output logic [NUM_PADS-1:0]   ef_n,
  output logic [NUM_PADS-1:0]   key_any,
  output logic [16*NUM_PADS-1:0] pad_state
);

  localparam int PW = 16 * NUM_PADS;

  // Top-row keys feed pad 0. The result is {hit, key}.
  function automatic logic [4:0] map_pad0(input logic [7:0] c);
    case (c)
      8'h45: map_pad0 = 5'h10;  8'h16: map_pad0 = 5'h11;
      8'h1E: map_pad0 = 5'h12;  8'h26: map_pad0 = 5'h13;
      8'h25: map_pad0 = 5'h14;  8'h2E: map_pad0 = 5'h15;
      8'h36: map_pad0 = 5'h16;  8'h3D: map_pad0 = 5'h17;
      8'h3E: map_pad0 = 5'h18;  8'h46: map_pad0 = 5'h19;
      8'h1C: map_pad0 = 5'h1A;  8'h32: map_pad0 = 5'h1B;
      8'h21: map_pad0 = 5'h1C;  8'h23: map_pad0 = 5'h1D;
      8'h24: map_pad0 = 5'h1E;  8'h2B: map_pad0 = 5'h1F;
      default: map_pad0 = 5'h00;
    endcase
  endfunction

  // Numeric keypad feeds pad 1 with digits only.
  function automatic logic [4:0] map_pad1(input logic [7:0] c);
    case (c)
      8'h70: map_pad1 = 5'h10;  8'h69: map_pad1 = 5'h11;
      8'h72: map_pad1 = 5'h12;  8'h7A: map_pad1 = 5'h13;
      8'h6B: map_pad1 = 5'h14;  8'h73: map_pad1 = 5'h15;
      8'h74: map_pad1 = 5'h16;  8'h6C: map_pad1 = 5'h17;
      8'h75: map_pad1 = 5'h18;  8'h7D: map_pad1 = 5'h19;
      default: map_pad1 = 5'h00;
    endcase
  endfunction

  logic          r_tog;
  logic [31:0]   r_ps2, w_ps2_nxt;
  logic [PW-1:0] r_ext1, r_ext2, w_ps2_pad, w_eff;
  logic [3:0]    r_key_sel;
  logic [NUM_PADS-1:0] r_ef_n, r_key_any, w_ef_nxt, w_any_nxt;
  logic [PW-1:0] r_pad_state;
  logic [4:0]    w_m0, w_m1;
  logic [3:0]    w_key [2];
  logic [1:0]    w_hit;
  logic          w_evt;
  logic          w_unused;

  // Extended (E0-prefixed) events only advance the toggle tracker.
  assign w_evt    = (ps2_key[10] != r_tog) & ~ps2_key[8];
  assign w_m0     = map_pad0(ps2_key[7:0]);
  assign w_m1     = map_pad1(ps2_key[7:0]);
  assign w_key[0] = w_m0[3:0];
  assign w_key[1] = w_m1[3:0];
  assign w_hit[0] = w_evt & w_m0[4];
  assign w_hit[1] = w_evt & w_m1[4] & (NUM_PADS > 1);
  assign w_unused = ^{io_dout[7:4], (MIN_HOLD > 0)};

`ifdef STUDIO2_KEY_STRETCH_EN
  localparam int CW = $clog2(MIN_HOLD + 1);
  logic [CW-1:0] r_cnt [2];
  logic [CW-1:0] w_cnt_nxt [2];
  logic [3:0]    r_skey [2];
  logic [3:0]    w_skey_nxt [2];
  logic [1:0]    r_pend, w_pend_nxt;
`endif

  always_comb begin
    w_ps2_nxt = r_ps2;
`ifdef STUDIO2_KEY_STRETCH_EN
    for (int p = 0; p < 2; p++) begin
      w_cnt_nxt[p]  = (r_cnt[p] != '0) ? r_cnt[p] - CW'(1) : '0;
      w_skey_nxt[p] = r_skey[p];
      w_pend_nxt[p] = r_pend[p];
      // The counter reaches zero at this edge, so the deferred release lands now.
      if (r_pend[p] && r_cnt[p] == CW'(1)) begin
        w_ps2_nxt[p*16 + int'(r_skey[p])] = 1'b0;
        w_pend_nxt[p] = 1'b0;
      end
      if (w_hit[p]) begin
        if (ps2_key[9]) begin
          // A new key flushes the old key's pending release. A re-make of
          // the same key simply cancels that release.
          if (r_pend[p] && r_skey[p] != w_key[p])
            w_ps2_nxt[p*16 + int'(r_skey[p])] = 1'b0;
          w_ps2_nxt[p*16 + int'(w_key[p])] = 1'b1;
          w_cnt_nxt[p]  = CW'(MIN_HOLD);
          w_skey_nxt[p] = w_key[p];
          w_pend_nxt[p] = 1'b0;
        end else if (w_key[p] == r_skey[p] && r_cnt[p] > CW'(1)) begin
          w_pend_nxt[p] = 1'b1;
        end else begin
          w_ps2_nxt[p*16 + int'(w_key[p])] = 1'b0;
        end
      end
    end
`else
    for (int p = 0; p < 2; p++) begin
      if (w_hit[p]) w_ps2_nxt[p*16 + int'(w_key[p])] = ps2_key[9];
    end
`endif
  end

  generate
    if (NUM_PADS <= 2) begin : g_ps2_narrow
      assign w_ps2_pad = r_ps2[PW-1:0];
    end else begin : g_ps2_wide
      assign w_ps2_pad = {{(PW-32){1'b0}}, r_ps2};
    end
  endgenerate

  assign w_eff = w_ps2_pad | r_ext2;

  always_comb begin
    w_ef_nxt  = '1;
    w_any_nxt = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      w_ef_nxt[p]  = ~w_eff[p*16 + int'(r_key_sel)];
      w_any_nxt[p] = |w_eff[p*16 +: 16];
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_tog       <= 1'b0;
      r_ps2       <= '0;
      r_ext1      <= '0;
      r_ext2      <= '0;
      r_key_sel   <= '0;
      r_ef_n      <= '1;
      r_key_any   <= '0;
      r_pad_state <= '0;
`ifdef STUDIO2_KEY_STRETCH_EN
      for (int p = 0; p < 2; p++) begin
        r_cnt[p]  <= '0;
        r_skey[p] <= '0;
      end
      r_pend <= '0;
`endif
    end else begin
      r_tog       <= ps2_key[10];
      r_ps2       <= w_ps2_nxt;
      r_ext1      <= ext_keys;
      r_ext2      <= r_ext1;
      r_pad_state <= w_eff;
      r_ef_n      <= w_ef_nxt;
      r_key_any   <= w_any_nxt;
      if (io_out && io_n == SEL_PORT) r_key_sel <= io_dout[3:0];
`ifdef STUDIO2_KEY_STRETCH_EN
      for (int p = 0; p < 2; p++) begin
        r_cnt[p]  <= w_cnt_nxt[p];
        r_skey[p] <= w_skey_nxt[p];
      end
      r_pend <= w_pend_nxt;
`endif
    end
  end

  assign key_sel   = r_key_sel;
  assign ef_n      = r_ef_n;
  assign key_any   = r_key_any;
  assign pad_state = r_pad_state;

endmodule

// File: tb/tb_studio2_keypad.sv
// Bench for studio2_keypad: a directed vector table, short hand-written
// timing and reset sequences, and a randomized run against a timestamp-based
// model of the held-key rules.
module tb_studio2_keypad;
  localparam int NP = 2;
  localparam int MH = 16;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic [31:0] ext_keys;
  logic        io_out;
  logic [2:0]  io_n;
  logic [7:0]  io_dout;
  logic [3:0]  key_sel;
  logic [1:0]  ef_n, key_any;
  logic [31:0] pad_state;

  always #5 clk_sys = ~clk_sys;

  studio2_keypad #(.NUM_PADS(NP), .MIN_HOLD(MH), .SEL_PORT(3'd2)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .ext_keys(ext_keys),
    .io_out(io_out), .io_n(io_n), .io_dout(io_dout), .key_sel(key_sel),
    .ef_n(ef_n), .key_any(key_any), .pad_state(pad_state));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] codes0 [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                              8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
  logic [7:0] codes1 [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C,
                              8'h75, 8'h7D};
  logic [15:0] m_ps2 [2];
  logic [31:0] m_e1, m_e2, m_ps;
  logic [3:0]  m_sel;
  logic        m_prev;
  logic [1:0]  m_ef, m_any;
  int          m_dead [2];
  int          m_skey [2];
  bit          m_pend [2];

  function automatic int lookup(input int pad, input logic [7:0] c);
    if (pad == 0) begin
      for (int i = 0; i < 16; i++) if (codes0[i] == c) return i;
    end else begin
      for (int i = 0; i < 10; i++) if (codes1[i] == c) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_ps2[p] = '0; m_dead[p] = -1; m_skey[p] = 0; m_pend[p] = 0;
    end
    m_e1 = '0; m_e2 = '0; m_ps = '0; m_sel = '0; m_prev = 1'b0;
    m_ef = 2'b11; m_any = 2'b00;
  endtask

  // Apply one mapped make/break at edge number cyc.
  task automatic model_key(input int p, input int k, input bit mk);
`ifdef STUDIO2_KEY_STRETCH_EN
    if (mk) begin
      if (m_pend[p] && m_skey[p] != k) m_ps2[p][m_skey[p]] = 1'b0;
      m_pend[p] = 0;
      m_ps2[p][k] = 1'b1;
      m_skey[p] = k;
      m_dead[p] = cyc + MH;
    end else if (k == m_skey[p] && cyc < m_dead[p]) begin
      m_pend[p] = 1;
    end else begin
      m_ps2[p][k] = 1'b0;
    end
`else
    m_ps2[p][k] = mk;
`endif
  endtask

  // Evaluates the edge about to happen, using the inputs currently applied.
  task automatic model_step();
    logic [31:0] eff;
    int k;
    eff = {m_ps2[1], m_ps2[0]} | m_e2;
    m_ps = eff;
    for (int p = 0; p < 2; p++) begin
      m_ef[p]  = ~eff[p*16 + m_sel];
      m_any[p] = |eff[p*16 +: 16];
    end
    m_e2 = m_e1;
    m_e1 = ext_keys;
    if (io_out && io_n == 3'd2) m_sel = io_dout[3:0];
`ifdef STUDIO2_KEY_STRETCH_EN
    for (int p = 0; p < 2; p++)
      if (m_pend[p] && cyc == m_dead[p]) begin
        m_ps2[p][m_skey[p]] = 1'b0;
        m_pend[p] = 0;
      end
`endif
    if (ps2_key[10] != m_prev) begin
      m_prev = ps2_key[10];
      if (!ps2_key[8])
        for (int p = 0; p < 2; p++) begin
          k = lookup(p, ps2_key[7:0]);
          if (k >= 0) model_key(p, k, ps2_key[9]);
        end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    model_step();
    @(posedge clk_sys);
    #1;
    cyc++;
    io_out = 1'b0;
  endtask

  task automatic ev(input logic [7:0] code, input bit mk, input bit x);
    ps2_key = {~ps2_key[10], mk, x, code};
  endtask

  task automatic wr(input logic [2:0] port, input logic [7:0] dat);
    io_out = 1'b1; io_n = port; io_dout = dat;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    ps2_key = '0; ext_keys = '0; io_out = 1'b0; io_n = '0; io_dout = '0;
    model_reset();
    repeat (3) @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] s, input logic [1:0] e,
                         input logic [1:0] a, input logic [31:0] ps);
    chk({tag, ".key_sel"}, 32'(key_sel), 32'(s));
    chk({tag, ".ef_n"}, 32'(ef_n), 32'(e));
    chk({tag, ".key_any"}, 32'(key_any), 32'(a));
    chk({tag, ".pad_state"}, pad_state, ps);
  endtask

  typedef struct {
    bit         ev;
    logic [7:0] code;
    bit         mk;
    bit         x;
    bit         wr;
    logic [2:0] port;
    logic [7:0] dat;
    logic [3:0] e_sel;
    logic [1:0] e_ef;
    logic [1:0] e_any;
    logic [31:0] e_ps;
  } vec_t;

  vec_t tbl [16];

  initial begin
    tbl[0]  = '{1'b1, 8'h16, 1'b1, 1'b0, 1'b1, 3'd2, 8'h01, 4'h1, 2'b10, 2'b01, 32'h0000_0002};
    tbl[1]  = '{1'b1, 8'h16, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 4'h1, 2'b11, 2'b00, 32'h0000_0000};
    tbl[2]  = '{1'b1, 8'h16, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 4'h1, 2'b10, 2'b01, 32'h0000_0002};
    tbl[3]  = '{1'b1, 8'h3E, 1'b1, 1'b0, 1'b1, 3'd2, 8'h08, 4'h8, 2'b10, 2'b01, 32'h0000_0102};
    tbl[4]  = '{1'b1, 8'h16, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 4'h8, 2'b10, 2'b01, 32'h0000_0100};
    tbl[5]  = '{1'b1, 8'h7A, 1'b1, 1'b0, 1'b1, 3'd2, 8'h03, 4'h3, 2'b01, 2'b11, 32'h0008_0100};
    tbl[6]  = '{1'b1, 8'h7A, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 4'h3, 2'b01, 2'b11, 32'h0008_0100};
    tbl[7]  = '{1'b1, 8'h7A, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 4'h3, 2'b01, 2'b11, 32'h0008_0100};
    tbl[8]  = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 4'h3, 2'b01, 2'b11, 32'h0008_0100};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 8'hF5, 4'h3, 2'b01, 2'b11, 32'h0008_0100};
    tbl[10] = '{1'b1, 8'h3E, 1'b0, 1'b0, 1'b1, 3'd2, 8'h08, 4'h8, 2'b11, 2'b10, 32'h0008_0000};
    tbl[11] = '{1'b1, 8'h2B, 1'b1, 1'b0, 1'b1, 3'd2, 8'h0F, 4'hF, 2'b10, 2'b11, 32'h0008_8000};
    tbl[12] = '{1'b1, 8'h7A, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 4'hF, 2'b10, 2'b01, 32'h0000_8000};
    tbl[13] = '{1'b1, 8'h7D, 1'b1, 1'b0, 1'b1, 3'd2, 8'hA9, 4'h9, 2'b01, 2'b11, 32'h0200_8000};
    tbl[14] = '{1'b1, 8'h2B, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 4'h9, 2'b01, 2'b10, 32'h0200_0000};
    tbl[15] = '{1'b1, 8'h7D, 1'b0, 1'b0, 1'b1, 3'd6, 8'h03, 4'h9, 2'b11, 2'b00, 32'h0000_0000};

    do_reset();
    chk_all("reset", 4'h0, 2'b11, 2'b00, 32'h0);

`ifndef STUDIO2_KEY_STRETCH_EN
    // Directed table: each vector is followed by two edges before checking.
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].ev) ev(tbl[i].code, tbl[i].mk, tbl[i].x);
      if (tbl[i].wr) wr(tbl[i].port, tbl[i].dat);
      tick();
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].e_sel, tbl[i].e_ef, tbl[i].e_any, tbl[i].e_ps);
    end
`endif

    // Exact latency: a select write and a make in the same cycle.
    do_reset();
    ev(8'h16, 1'b1, 1'b0);
    wr(3'd2, 8'h01);
    tick();
    chk("lat.sel_1cyc", 32'(key_sel), 32'h1);
    chk("lat.ef_1cyc", 32'(ef_n), 32'h3);
    tick();
    chk("lat.ef_2cyc", 32'(ef_n), 32'h2);
`ifndef STUDIO2_KEY_STRETCH_EN
    ev(8'h16, 1'b0, 1'b0);
    tick();
    chk("brk.ef_1cyc", 32'(ef_n), 32'h2);
    tick();
    chk("brk.ef_2cyc", 32'(ef_n), 32'h3);
`else
    // A short tap stays visible until MIN_HOLD edges after the make.
    do_reset();
    wr(3'd2, 8'h01);
    tick();
    ev(8'h16, 1'b1, 1'b0);
    tick();
    for (int j = 1; j <= 17; j++) begin
      if (j == 3) ev(8'h16, 1'b0, 1'b0);
      tick();
      if (j == 16) chk("stretch.held_at_16", 32'(pad_state[1]), 32'h1);
      if (j == 17) chk("stretch.clear_at_17", 32'(pad_state[1]), 32'h0);
      if (j == 17) chk("stretch.ef_at_17", 32'(ef_n), 32'h3);
    end
`endif

    // Randomized run against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        int r;
        logic [7:0] c;
        r = $urandom_range(0, 9);
        if (r < 5)      c = codes0[$urandom_range(0, 15)];
        else if (r < 9) c = codes1[$urandom_range(0, 9)];
        else            c = 8'($urandom);
        ev(c, ($urandom_range(0, 1) == 1), ($urandom_range(0, 7) == 0));
      end
      if ($urandom_range(0, 3) == 0)
        wr(($urandom_range(0, 1) == 1) ? 3'd2 : 3'($urandom_range(0, 7)), 8'($urandom));
      if ($urandom_range(0, 15) == 0) ext_keys = $urandom & $urandom & $urandom;
      tick();
      chk("rnd.key_sel", 32'(key_sel), 32'(m_sel));
      chk("rnd.ef_n", 32'(ef_n), 32'(m_ef));
      chk("rnd.key_any", 32'(key_any), 32'(m_any));
      chk("rnd.pad_state", pad_state, m_ps);
    end

    // Asynchronous reset with keys held, then the external-key path.
    do_reset();
    wr(3'd2, 8'h03);
    ev(8'h16, 1'b1, 1'b0);
    tick();
    ev(8'h7A, 1'b1, 1'b0);
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("async_rst", 4'h0, 2'b11, 2'b00, 32'h0);
    ps2_key = '0;
    model_reset();
    @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    ext_keys = 32'h0000_0020;
    wr(3'd2, 8'h05);
    tick();
    tick();
    chk("ext.ef_2cyc", 32'(ef_n), 32'h3);
    tick();
    chk_all("ext.3cyc", 4'h5, 2'b10, 2'b01, 32'h0000_0020);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/studio2_keypad.md
# studio2_keypad

Parametrised keypad controller for the Studio II core, replacing the single-code keypad register in the top level. It decodes PS/2 make/break events and optional external (joystick-mapped) inputs into a per-pad 16-key held bitmap. It latches the key number the CPU writes to port N=2 and drives the active-low EF3/EF4-style flags for the selected key on each pad. An optional stretch ensures very short taps stay visible to the software scan loop.

## Interface

Parameters:
- NUM_PADS, 2: number of keypads, 1..4; PS/2 maps only pads 0 and 1.
- MIN_HOLD, 65536: minimum visible hold in clk_sys cycles, used only with the stretch feature; must be ≥1.
- SEL_PORT, 3'd2: io_n value whose OUT strobe loads the key select.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- ps2_key  in  11  [10] toggle per event, [9] pressed, [8] extended, [7:0] scan code.
- ext_keys  in  16*NUM_PADS  level inputs; bit p*16+k holds key k of pad p.
- io_out  in  1  CPU output strobe, one cycle.
- io_n  in  3  CPU N lines.
- io_dout  in  8  CPU output data; [3:0] used.
- key_sel  out  4  latched key select.
- ef_n  out  NUM_PADS  low when the selected key on pad p is held.
- key_any  out  NUM_PADS  high when any key on pad p is held.
- pad_state  out  16*NUM_PADS  effective held bitmap (PS/2 OR stretch OR ext_keys).

## Operation

- Reset (reset_n=0, asynchronous): ps2 bitmaps = 0, toggle tracker = 0, key_sel = 0, stretch counters = 0, ef_n = all 1, key_any = 0, pad_state = 0.
- PS/2 event: detected when ps2_key[10] differs from the registered previous toggle. Events with ps2_key[8]=1 are ignored (tracker still updates).
- Pad 0 map (top row): 45→0, 16→1, 1E→2, 26→3, 25→4, 2E→5, 36→6, 3D→7, 3E→8, 46→9, 1C→A, 32→B, 21→C, 23→D, 24→E, 2B→F.
- Pad 1 map (numeric keypad): 70→0, 69→1, 72→2, 7A→3, 6B→4, 73→5, 74→6, 6C→7, 75→8, 7D→9. Pad 1 has no A–F PS/2 mapping.
- Unmapped codes: no state change.
- On a mapped make event, set the bit. On a mapped break event, clear the bit, subject to stretch.
- Multiple keys may be held at once. Bitmaps are independent per key, with no last-key-wins behaviour.
- Key select: io_out=1 with io_n==SEL_PORT loads key_sel ← io_dout[3:0]. All other OUTs are ignored.
- ef_n[p] = ~pad_state[p*16+key_sel]. key_any[p] = |pad_state[p*16+:16].
- ext_keys are synchronised through 2 flops, then ORed into pad_state. They are not affected by stretch.

## Timing

- PS/2 event to ps2 bitmap update: 1 cycle after the toggle is seen.
- pad_state, key_any and ef_n are registered: 1 further cycle. Total latency from ps2_key toggle to ef_n is 2 clk_sys cycles.
- io_out strobe to key_sel: 1 cycle. key_sel to ef_n: 1 cycle.
- A select write and a PS/2 event in the same cycle are both applied. ef_n then reflects the new key_sel and the new bitmap 2 cycles later.
- ext_keys to ef_n: 3 cycles (2 sync + 1 output register).
- reset_n deassertion is used directly; the codebase reset synchroniser is the source.

## Configuration

- STUDIO2_KEY_STRETCH_EN defined:
  - Each pad has one counter (width $clog2(MIN_HOLD+1)) and a 4-bit stretch key.
  - A make event on pad p loads counter ← MIN_HOLD and stretch key ← k. The counter decrements each cycle to 0 and saturates there.
  - A break of the stretch key while counter≠0 sets a pending-clear flag. The bit clears on the cycle the counter reaches 0.
  - A break with counter=0, or a break of a non-stretch key, clears the bit immediately.
  - A new make on the same pad during a pending clear applies the pending clear to the old key at once, then restarts the counter for the new key.
  - A re-make of the pending key cancels the pending clear.
- STUDIO2_KEY_STRETCH_EN undefined: no counters. A break clears the bit immediately and MIN_HOLD is unused.

## Test plan

- Reset, then make code 16 (pad 0 key 1) and OUT port 2 with data 8'h01: key_sel=1, ef_n[0]=0, key_any=2'b01. Break 16: ef_n[0]=1 two cycles after the toggle (stretch off).
- Make 16 and 3E, then select 8: ef_n[0]=0. Break 16: ef_n[0] stays 0 and pad_state[8] stays 1.
- Make 7A (pad 1 key 3), select 3: ef_n=2'b01. Make E0-extended 7A: no change. Make code 0x5A: no change.
- OUT on io_n=1 with data 5: key_sel unchanged. An OUT port 2 write and a make event in the same cycle: both are reflected in ef_n two cycles later.
- Stretch on, MIN_HOLD=16: make then break 16 after 3 cycles. pad_state[1] stays 1 until 16 cycles after the make, then clears.
- Assert reset_n=0 mid-stretch with keys held: all outputs reach reset values immediately. ext_keys[5]=1 gives ef_n[0]=0 three cycles after release, with key_sel=5 written.
